stdp_synapse: RTL
=================

// Module: stdp_synapse
// PURPOSE
// Receiving end of the LIF spike interface: consumes presynaptic and postsynaptic spike
// pulses from two lif neurons, applies a pair-based STDP rule to an 8-bit synaptic weight,
// and drives the weighted synaptic current back into the postsynaptic neuron's current input.
// Timing is measured in clock cycles. The exponential STDP window is approximated by
// halving the update step every 2^TAU_SHIFT cycles.
// PARAMETERS
// W_INIT     64  weight value loaded at reset
// W_MAX      255 upper clamp for weight
// W_MIN      0   lower clamp for weight
// A_PLUS     32  LTP step at dt=1..2^TAU_SHIFT
// A_MINUS    32  LTD step at dt=1..2^TAU_SHIFT
// TAU_SHIFT  2   log2 of cycles per halving of step
// WINDOW     16  max |dt| (cycles) that pairs; 1..255
// PORTS
// clk          in   1  clock, all state on rising edge
// rst_n        in   1  asynchronous active-low reset
// pre_spike    in   1  presynaptic spike, 1-cycle pulse (lif spike output)
// post_spike   in   1  postsynaptic spike, 1-cycle pulse
// learn_en     in   1  1 = weight updates allowed
// weight       out  8  current synaptic weight (register)
// syn_current  out  8  weight gated by pre_spike, to postsynaptic lif current input
// update_flag  out  1  1-cycle pulse when a weight update is applied
// update_dir   out  1  1 = LTP, 0 = LTD; valid while update_flag=1
// dt_out       out  8  |dt| of the pairing that caused the update; holds until next update
// BEHAVIOUR
// - Reset (async, any time incl. mid-pipeline): weight=W_INIT; syn_current, update_flag,
//   update_dir, dt_out = 0; both traces invalid, counters 0; pipeline stage empty.
// - Traces: pre/post each own an 8-bit counter + valid bit. On its spike: counter<=1, valid<=1.
//   Otherwise if valid: counter+1; valid cleared when counter would exceed WINDOW.
//   A spike at edge n seen by partner spike at edge n+k gives dt=k exactly (1<=k<=WINDOW).
// - LTP: post_spike & pre valid & !pre_spike -> delta=A_PLUS>>((dt-1)>>TAU_SHIFT), dir=1;
//   pre trace invalidated (each pre pairs with at most one post).
// - LTD: pre_spike & post valid & !post_spike -> delta=A_MINUS>>((dt-1)>>TAU_SHIFT), dir=0;
//   post trace invalidated.
// - Simultaneous pre_spike & post_spike (same edge): no update; both traces restart at 1.
// - learn_en=0: no events enter the pipeline; traces and syn_current operate normally.
// - Pipeline: edge n: event detected, delta/dir/dt registered (stage 1). Edge n+1: weight
//   updated, update_flag=1 for one cycle, update_dir/dt_out loaded. At most one event per
//   edge; back-to-back events on consecutive edges both apply in order.
// - Arithmetic: 9-bit intermediate; LTP weight=min(weight+delta, W_MAX);
//   LTD weight=max(weight-delta, W_MIN). No wrap-around ever. delta=0 still pulses flag.
// - syn_current: registered; at edge n = pre_spike ? weight (pre-update value) : 0.
//   Latency 1 cycle, high for exactly one cycle per pre spike.
// TESTING
// 1 reset: rst_n low mid-run -> weight=64, syn_current=0, update_flag=0 immediately (async).
// 2 pre edge 10, post edge 13 (dt=3) -> after edge 14 weight=96, flag 1 cycle, dir=1, dt_out=3;
//   second post at edge 15 -> no update (pre consumed).
// 3 post edge 10, pre edge 20 (dt=10) -> weight 64->56 after edge 21, dir=0;
//   syn_current=64 for the cycle after edge 20.
// 4 pre edge 10, post edge 27 (dt=17) -> no update; pre & post same edge -> no update.
// 5 saturation: weight 240 + LTP dt=1 -> 255; weight 10 + LTD dt=1 -> 0; no wrap.
// 6 learn_en=0 with pairing dt=2 -> weight unchanged, flag never set, syn_current still pulses.

Source files
------------

// File: rtl/stdp_synapse_if.sv
// -----------------------------------------------------------------------------
// stdp_synapse_if
// Bundles the spike inputs and learning outputs exchanged between the spiking
// front end (two LIF neurons plus a learning enable) and the STDP synapse.
//   pre_spike   : presynaptic spike, 1-cycle pulse
//   post_spike  : postsynaptic spike, 1-cycle pulse
//   learn_en    : 1 = weight updates allowed
//   weight      : current synaptic weight
//   syn_current : weight gated by pre_spike, fed to the postsynaptic neuron
//   update_flag : 1-cycle pulse when a weight update is applied
//   update_dir  : 1 = potentiation, 0 = depression (valid with update_flag)
//   dt_out      : |dt| of the pairing behind the latest update
// master = spike source / observer, slave = the synapse itself.
// -----------------------------------------------------------------------------
interface stdp_synapse_if;
  logic       pre_spike;
  logic       post_spike;
  logic       learn_en;
  logic [7:0] weight;
  logic [7:0] syn_current;
  logic       update_flag;
  logic       update_dir;
  logic [7:0] dt_out;

  modport master (
    output pre_spike, post_spike, learn_en,
    input  weight, syn_current, update_flag, update_dir, dt_out
  );

  modport slave (
    input  pre_spike, post_spike, learn_en,
    output weight, syn_current, update_flag, update_dir, dt_out
  );
endinterface

// File: rtl/stdp_synapse.sv
// -----------------------------------------------------------------------------
// stdp_synapse
// Pair-based STDP synapse between two LIF neurons. Each side keeps a trace
// (cycle counter + valid bit) started by its own spike. A partner spike that
// finds a valid trace forms a pairing with dt = counter value; the update step
// halves every 2^TAU_SHIFT cycles of dt. Detected events are registered in a
// one-deep stage and applied to the saturating 8-bit weight on the next edge.
// Ports:
//   clk   : clock, all state on the rising edge
//   rst_n : asynchronous active-low reset
//   bus   : stdp_synapse_if.slave (spike inputs, weight/current/update outputs)
// -----------------------------------------------------------------------------
module stdp_synapse #(
  parameter int W_INIT    = 64,
  parameter int W_MAX     = 255,
  parameter int W_MIN     = 0,
  parameter int A_PLUS    = 32,
  parameter int A_MINUS   = 32,
  parameter int TAU_SHIFT = 2,
  parameter int WINDOW    = 16
) (
  input  logic           clk,
  input  logic           rst_n,
  stdp_synapse_if.slave  bus
);

  localparam logic [7:0] W_INIT_B  = 8'(W_INIT);
  localparam logic [8:0] W_MAX_9   = 9'(W_MAX);
  localparam logic [8:0] W_MIN_9   = 9'(W_MIN);
  localparam logic [7:0] W_MAX_B   = 8'(W_MAX);
  localparam logic [7:0] W_MIN_B   = 8'(W_MIN);
  localparam logic [7:0] A_PLUS_B  = 8'(A_PLUS);
  localparam logic [7:0] A_MINUS_B = 8'(A_MINUS);
  localparam logic [8:0] WINDOW_9  = 9'(WINDOW);

  // Exponential window approximation: amplitude halved once per 2^TAU_SHIFT
  // cycles of dt, with dt = 1 .. 2^TAU_SHIFT receiving the full amplitude.
  function automatic logic [7:0] step_size(input logic [7:0] amp, input logic [7:0] dt);
    logic [7:0] sh;
    sh = (dt - 8'd1) >> TAU_SHIFT;
    return amp >> sh;
  endfunction

  // Traces
  logic [7:0] pre_cnt_q,  pre_cnt_d;
  logic       pre_vld_q,  pre_vld_d;
  logic [7:0] post_cnt_q, post_cnt_d;
  logic       post_vld_q, post_vld_d;

  // Event stage
  logic       ev_vld_q,   ev_vld_d;
  logic       ev_dir_q,   ev_dir_d;
  logic [7:0] ev_delta_q, ev_delta_d;
  logic [7:0] ev_dt_q,    ev_dt_d;

  // Outputs
  logic [7:0] weight_q,      weight_d;
  logic [7:0] syn_current_q, syn_current_d;
  logic       update_flag_q, update_flag_d;
  logic       update_dir_q,  update_dir_d;
  logic [7:0] dt_out_q,      dt_out_d;

  logic       ltp_hit;
  logic       ltd_hit;
  logic [8:0] sum_9;
  logic [8:0] diff_9;

  // A spike on both sides at the same edge never pairs.
  assign ltp_hit = bus.learn_en & bus.post_spike & pre_vld_q  & ~bus.pre_spike;
  assign ltd_hit = bus.learn_en & bus.pre_spike  & post_vld_q & ~bus.post_spike;

  // Trace update. A consumed trace is dropped so one spike pairs at most once;
  // the trace counts up to WINDOW and expires on the step past it.
  always_comb begin
    pre_cnt_d  = pre_cnt_q;
    pre_vld_d  = pre_vld_q;
    post_cnt_d = post_cnt_q;
    post_vld_d = post_vld_q;

    if (bus.pre_spike) begin
      pre_cnt_d = 8'd1;
      pre_vld_d = 1'b1;
    end else if (ltp_hit) begin
      pre_cnt_d = 8'd0;
      pre_vld_d = 1'b0;
    end else if (pre_vld_q) begin
      if (({1'b0, pre_cnt_q} + 9'd1) > WINDOW_9) begin
        pre_cnt_d = 8'd0;
        pre_vld_d = 1'b0;
      end else begin
        pre_cnt_d = pre_cnt_q + 8'd1;
      end
    end

    if (bus.post_spike) begin
      post_cnt_d = 8'd1;
      post_vld_d = 1'b1;
    end else if (ltd_hit) begin
      post_cnt_d = 8'd0;
      post_vld_d = 1'b0;
    end else if (post_vld_q) begin
      if (({1'b0, post_cnt_q} + 9'd1) > WINDOW_9) begin
        post_cnt_d = 8'd0;
        post_vld_d = 1'b0;
      end else begin
        post_cnt_d = post_cnt_q + 8'd1;
      end
    end
  end

  // Event capture
  always_comb begin
    ev_vld_d   = ltp_hit | ltd_hit;
    ev_dir_d   = 1'b0;
    ev_delta_d = 8'd0;
    ev_dt_d    = 8'd0;
    if (ltp_hit) begin
      ev_dir_d   = 1'b1;
      ev_delta_d = step_size(A_PLUS_B, pre_cnt_q);
      ev_dt_d    = pre_cnt_q;
    end else if (ltd_hit) begin
      ev_dir_d   = 1'b0;
      ev_delta_d = step_size(A_MINUS_B, post_cnt_q);
      ev_dt_d    = post_cnt_q;
    end
  end

  // Weight application with 9-bit headroom so the clamp sees any overflow/borrow.
  assign sum_9  = {1'b0, weight_q} + {1'b0, ev_delta_q};
  assign diff_9 = {1'b0, weight_q} - {1'b0, ev_delta_q};

  always_comb begin
    weight_d      = weight_q;
    update_flag_d = ev_vld_q;
    update_dir_d  = update_dir_q;
    dt_out_d      = dt_out_q;
    if (ev_vld_q) begin
      update_dir_d = ev_dir_q;
      dt_out_d     = ev_dt_q;
      if (ev_dir_q) begin
        weight_d = (sum_9 > W_MAX_9) ? W_MAX_B : sum_9[7:0];
      end else begin
        // diff_9[8] is the borrow: the true result went below zero.
        weight_d = (diff_9[8] || (diff_9 < W_MIN_9)) ? W_MIN_B : diff_9[7:0];
      end
    end
  end

  // Current pulse carries the weight as it stood before this edge's update.
  assign syn_current_d = bus.pre_spike ? weight_q : 8'd0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pre_cnt_q     <= 8'd0;
      pre_vld_q     <= 1'b0;
      post_cnt_q    <= 8'd0;
      post_vld_q    <= 1'b0;
      ev_vld_q      <= 1'b0;
      ev_dir_q      <= 1'b0;
      ev_delta_q    <= 8'd0;
      ev_dt_q       <= 8'd0;
      weight_q      <= W_INIT_B;
      syn_current_q <= 8'd0;
      update_flag_q <= 1'b0;
      update_dir_q  <= 1'b0;
      dt_out_q      <= 8'd0;
    end else begin
      pre_cnt_q     <= pre_cnt_d;
      pre_vld_q     <= pre_vld_d;
      post_cnt_q    <= post_cnt_d;
      post_vld_q    <= post_vld_d;
      ev_vld_q      <= ev_vld_d;
      ev_dir_q      <= ev_dir_d;
      ev_delta_q    <= ev_delta_d;
      ev_dt_q       <= ev_dt_d;
      weight_q      <= weight_d;
      syn_current_q <= syn_current_d;
      update_flag_q <= update_flag_d;
      update_dir_q  <= update_dir_d;
      dt_out_q      <= dt_out_d;
    end
  end

  assign bus.weight      = weight_q;
  assign bus.syn_current = syn_current_q;
  assign bus.update_flag = update_flag_q;
  assign bus.update_dir  = update_dir_q;
  assign bus.dt_out      = dt_out_q;

endmodule
